// File: rtl/systolic_cluster_sequencer_if.sv
// Command, operand-handshake and result-readback bundle between the job
// dispatcher / result consumer (master) and the systolic cluster sequencer (slave).
interface systolic_cluster_sequencer_if #(
  parameter int LEN_W = 8,
  parameter int IDX_W = 3,
  parameter int ROW_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_clear;

  logic             op_valid;
  logic             op_ready;

  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_array;
  logic [ROW_W-1:0] res_row;
  logic             res_last;

  modport master (
    output cmd_valid, cmd_len, cmd_clear, op_valid, res_ready,
    input  cmd_ready, op_ready, res_valid, res_array, res_row, res_last
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_clear, op_valid, res_ready,
    output cmd_ready, op_ready, res_valid, res_array, res_row, res_last
  );
endinterface

// File: rtl/systolic_cluster_sequencer.sv
// Systolic cluster sequencer: accepts matrix-multiply jobs, allocates a free
// array round-robin, sequences clear / weight load / compute / drain on it,
// and queues finished arrays for row-by-row result readback.
// Optional build macro: SEQ_PERF_CNT_EN adds saturating 32-bit perf counters
// (perf_jobs, perf_op_stall, perf_full_stall).
module systolic_cluster_sequencer #(
  parameter int NUM_ARRAYS = 8,
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_BITS  = 16,
  parameter int LEN_W      = 8,
  parameter int IDX_W      = $clog2(NUM_ARRAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  systolic_cluster_sequencer_if.slave bus,
  output logic [NUM_ARRAYS-1:0] arr_clear_acc,
  output logic [NUM_ARRAYS-1:0] arr_load_weights,
  output logic [NUM_ARRAYS-1:0] arr_compute_enable,
  output logic [IDX_W-1:0]      busy_array,
  output logic [NUM_ARRAYS-1:0] free_mask
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_jobs,
  output logic [31:0]           perf_op_stall,
  output logic [31:0]           perf_full_stall
`endif
);

  localparam int ROW_W     = $clog2(ARRAY_SIZE);
  localparam int DRAIN_CYC = 2 * ARRAY_SIZE - 2;
  localparam int CNT_W     = (LEN_W > $clog2(2 * ARRAY_SIZE)) ? LEN_W : $clog2(2 * ARRAY_SIZE);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  // Elaboration-time sanity of the configuration.
  generate
    if (NUM_ARRAYS < 2 || NUM_ARRAYS > 16) begin : g_bad_num_arrays
      $error("NUM_ARRAYS must be in 2..16");
    end
    if (ARRAY_SIZE < 2) begin : g_bad_array_size
      $error("ARRAY_SIZE must be at least 2");
    end
    if (DATA_BITS < 1) begin : g_bad_data_bits
      $error("DATA_BITS must be positive");
    end
  endgenerate

  // Index arithmetic modulo NUM_ARRAYS (works for non-power-of-two clusters).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_ARRAYS) s = s - NUM_ARRAYS;
    return IDX_W'(s);
  endfunction

  // ---------------------------------------------------------------- state
  logic                  active_q, active_d;
  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      busy_q, busy_d;
  logic [LEN_W-1:0]      k_q, k_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [NUM_ARRAYS-1:0] free_q, free_d;
  logic [IDX_W-1:0]      mem_q [NUM_ARRAYS];
  logic [IDX_W-1:0]      mem_d [NUM_ARRAYS];
  logic [IDX_W-1:0]      wr_q, wr_d;
  logic [IDX_W-1:0]      rd_q, rd_d;
  logic [IDX_W:0]        cnt_q, cnt_d;
  logic [ROW_W-1:0]      row_q, row_d;

  // ---------------------------------------------------------------- comb nets
  logic                  cmd_ready_int;
  logic                  cmd_fire;
  logic                  alloc;
  logic                  push;
  logic                  pop;
  logic                  res_valid_int;
  logic                  res_last_int;
  logic                  res_fire;
  logic [IDX_W-1:0]      head;
  logic                  alloc_found;
  logic [IDX_W-1:0]      alloc_idx;
  logic [CNT_W:0]        beat_inc;
  logic                  clear_on;
  logic                  load_on;
  logic                  comp_on;

  assign cmd_ready_int = active_q && (state_q == S_IDLE) && (free_q != '0);
  assign cmd_fire      = bus.cmd_valid && cmd_ready_int;
  assign res_valid_int = (cnt_q != '0);
  assign head          = mem_q[rd_q];
  assign res_last_int  = (row_q == ROW_W'(ARRAY_SIZE - 1));
  assign res_fire      = res_valid_int && bus.res_ready;
  assign pop           = res_fire && res_last_int;
  assign beat_inc      = {1'b0, beat_q} + 1'b1;

  assign clear_on = (state_q == S_CLEAR);
  assign load_on  = (state_q == S_LOAD) && bus.op_valid;
  assign comp_on  = ((state_q == S_COMPUTE) && bus.op_valid) || (state_q == S_DRAIN);

  assign bus.cmd_ready = cmd_ready_int;
  assign bus.op_ready  = (state_q == S_LOAD) || (state_q == S_COMPUTE);
  assign bus.res_valid = res_valid_int;
  assign bus.res_array = res_valid_int ? head : '0;
  assign bus.res_row   = row_q;
  assign bus.res_last  = res_last_int;

  assign busy_array = busy_q;
  assign free_mask  = free_q;

  // One-hot control decode: only the array being sequenced sees a pulse.
  generate
    for (genvar gi = 0; gi < NUM_ARRAYS; gi++) begin : g_ctrl
      assign arr_clear_acc[gi]      = clear_on && (busy_q == IDX_W'(gi));
      assign arr_load_weights[gi]   = load_on  && (busy_q == IDX_W'(gi));
      assign arr_compute_enable[gi] = comp_on  && (busy_q == IDX_W'(gi));
    end
  endgenerate

  // Round-robin pick: scanning downward leaves the closest free array at/after rr_q.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = NUM_ARRAYS - 1; i >= 0; i--) begin
      if (free_q[wrap_add(rr_q, i)]) begin
        alloc_found = 1'b1;
        alloc_idx   = wrap_add(rr_q, i);
      end
    end
  end

  // Job sequencing FSM: allocate, clear, load weights, compute K beats, drain.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    k_d     = k_q;
    beat_d  = beat_q;
    rr_d    = rr_q;
    alloc   = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire && alloc_found) begin
          alloc   = 1'b1;
          busy_d  = alloc_idx;
          rr_d    = wrap_add(alloc_idx, 1);
          k_d     = (bus.cmd_len == '0) ? LEN_W'(1) : bus.cmd_len;
          beat_d  = '0;
          state_d = bus.cmd_clear ? S_CLEAR : S_LOAD;
        end
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: begin
        if (bus.op_valid) begin
          if (beat_q == CNT_W'(ARRAY_SIZE - 1)) begin
            beat_d  = '0;
            state_d = S_COMPUTE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (bus.op_valid) begin
          if (beat_inc == (CNT_W + 1)'(k_q)) begin
            beat_d  = '0;
            state_d = S_DRAIN;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (beat_q == CNT_W'(DRAIN_CYC - 1)) begin
          beat_d  = '0;
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Free mask: allocation clears a bit, final readback row sets it back.
  always_comb begin
    free_d = free_q;
    if (alloc) free_d[alloc_idx] = 1'b0;
    if (pop)   free_d[head]      = 1'b1;
  end

  // Done FIFO and readback row counter; holds at most NUM_ARRAYS entries.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    row_d = row_q;
    if (push) begin
      mem_d[wr_q] = busy_q;
      wr_d        = wrap_add(wr_q, 1);
    end
    if (pop) rd_d = wrap_add(rd_q, 1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (res_fire) row_d = res_last_int ? '0 : row_q + 1'b1;
  end

  // active_q holds cmd_ready low until the first clock after reset release.
  assign active_d = 1'b1;

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      state_q  <= S_IDLE;
      busy_q   <= '0;
      k_q      <= '0;
      beat_q   <= '0;
      rr_q     <= '0;
      free_q   <= '1;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      row_q    <= '0;
      for (int i = 0; i < NUM_ARRAYS; i++) mem_q[i] <= '0;
    end else begin
      active_q <= active_d;
      state_q  <= state_d;
      busy_q   <= busy_d;
      k_q      <= k_d;
      beat_q   <= beat_d;
      rr_q     <= rr_d;
      free_q   <= free_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      for (int i = 0; i < NUM_ARRAYS; i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_jobs_q, perf_jobs_d;
  logic [31:0] perf_op_stall_q, perf_op_stall_d;
  logic [31:0] perf_full_stall_q, perf_full_stall_d;

  // Saturating event counters.
  always_comb begin
    perf_jobs_d       = perf_jobs_q;
    perf_op_stall_d   = perf_op_stall_q;
    perf_full_stall_d = perf_full_stall_q;
    if (push && !(&perf_jobs_q)) perf_jobs_d = perf_jobs_q + 1'b1;
    if (((state_q == S_LOAD) || (state_q == S_COMPUTE)) && !bus.op_valid && !(&perf_op_stall_q))
      perf_op_stall_d = perf_op_stall_q + 1'b1;
    if (bus.cmd_valid && (free_q == '0) && !(&perf_full_stall_q))
      perf_full_stall_d = perf_full_stall_q + 1'b1;
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_jobs_q       <= '0;
      perf_op_stall_q   <= '0;
      perf_full_stall_q <= '0;
    end else begin
      perf_jobs_q       <= perf_jobs_d;
      perf_op_stall_q   <= perf_op_stall_d;
      perf_full_stall_q <= perf_full_stall_d;
    end
  end

  assign perf_jobs       = perf_jobs_q;
  assign perf_op_stall   = perf_op_stall_q;
  assign perf_full_stall = perf_full_stall_q;
`endif

endmodule

// File: tb/tb_systolic_cluster_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic, with a
// job-level reference model (per-job beat budgets, free set, done queue).
module tb_systolic_cluster_sequencer;
  localparam int NA    = 4;
  localparam int AS    = 8;
  localparam int LW    = 8;
  localparam int IW    = $clog2(NA);
  localparam int RW    = $clog2(AS);
  localparam int DRAIN = 2 * AS - 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  systolic_cluster_sequencer_if #(.LEN_W(LW), .IDX_W(IW), .ROW_W(RW)) bus_if ();

  logic [NA-1:0] arr_clear_acc, arr_load_weights, arr_compute_enable, free_mask;
  logic [IW-1:0] busy_array;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_jobs, perf_op_stall, perf_full_stall;
`endif

  systolic_cluster_sequencer #(
    .NUM_ARRAYS(NA), .ARRAY_SIZE(AS), .DATA_BITS(16), .LEN_W(LW)
  ) u_dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus_if),
    .arr_clear_acc      (arr_clear_acc),
    .arr_load_weights   (arr_load_weights),
    .arr_compute_enable (arr_compute_enable),
    .busy_array         (busy_array),
    .free_mask          (free_mask)
`ifdef SEQ_PERF_CNT_EN
    ,
    .perf_jobs          (perf_jobs),
    .perf_op_stall      (perf_op_stall),
    .perf_full_stall    (perf_full_stall)
`endif
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- stimulus modes
  int op_mode  = 0;  // 0 always valid, 1 toggle, 2 random
  int res_mode = 0;  // 0 never ready, 1 always ready, 2 random

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_len   = '0;
    bus_if.cmd_clear = 1'b0;
    bus_if.op_valid  = 1'b0;
    bus_if.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (op_mode)
        0:       bus_if.op_valid = 1'b1;
        1:       bus_if.op_valid = ~bus_if.op_valid;
        default: bus_if.op_valid = 1'($urandom_range(0, 1));
      endcase
      case (res_mode)
        0:       bus_if.res_ready = 1'b0;
        1:       bus_if.res_ready = 1'b1;
        default: bus_if.res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------------------------------------------------------- reference model
  bit            m_started, m_job, m_clr;
  int            m_load_left, m_comp_left, m_drain_left;
  int            m_busy, m_rr, m_row, m_jobs_done;
  logic [NA-1:0] m_free;
  int            m_fifo[$];

  // observed pulse statistics for directed scenarios
  int cyc, cnt_clr, cnt_load, cnt_comp, first_load, last_load;

  task automatic model_reset();
    m_started = 0; m_job = 0; m_clr = 0;
    m_load_left = 0; m_comp_left = 0; m_drain_left = 0;
    m_busy = 0; m_rr = 0; m_row = 0; m_jobs_done = 0;
    m_free = '1;
    m_fifo.delete();
  endtask

  initial begin
    logic [NA-1:0] bitv, e_clr, e_load, e_comp;
    bit e_cmd_rdy, e_op_rdy, e_rv, ops_done;
    int a;
    model_reset();
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (|arr_clear_acc) cnt_clr++;
      if (|arr_compute_enable) cnt_comp++;
      if (|arr_load_weights) begin
        cnt_load++;
        if (first_load < 0) first_load = cyc;
        last_load = cyc;
      end
      if (!reset) begin
        check_val("rst_arr", {arr_clear_acc, arr_load_weights, arr_compute_enable}, 0);
        check_val("rst_ready", {bus_if.cmd_ready, bus_if.op_ready, bus_if.res_valid, bus_if.res_last}, 0);
        check_val("rst_res", {bus_if.res_array, bus_if.res_row, busy_array}, 0);
        check_val("rst_free", free_mask, {NA{1'b1}});
        model_reset();
      end else begin
        bitv      = NA'(1) << m_busy;
        ops_done  = (m_load_left + m_comp_left) == 0;
        e_cmd_rdy = m_started && !m_job && (m_free != '0);
        e_op_rdy  = m_job && !m_clr && !ops_done;
        e_clr     = (m_job && m_clr) ? bitv : '0;
        e_load    = (e_op_rdy && m_load_left > 0 && bus_if.op_valid) ? bitv : '0;
        e_comp    = ((e_op_rdy && m_load_left == 0 && bus_if.op_valid) || (m_job && !m_clr && ops_done)) ? bitv : '0;
        e_rv      = m_fifo.size() > 0;
        check_val("onehot", 32'($countones({arr_clear_acc, arr_load_weights, arr_compute_enable}) <= 1), 1);
        check_val("cmd_ready", bus_if.cmd_ready, e_cmd_rdy);
        check_val("op_ready", bus_if.op_ready, e_op_rdy);
        check_val("clear_acc", arr_clear_acc, e_clr);
        check_val("load_w", arr_load_weights, e_load);
        check_val("comp_en", arr_compute_enable, e_comp);
        check_val("busy_array", busy_array, m_busy);
        check_val("free_mask", free_mask, m_free);
        check_val("res_valid", bus_if.res_valid, e_rv);
        if (e_rv) check_val("res_array", bus_if.res_array, m_fifo[0]);
        check_val("res_row", bus_if.res_row, m_row);
        check_val("res_last", bus_if.res_last, m_row == AS - 1);
        // advance the job in progress
        if (m_job) begin
          if (m_clr) m_clr = 0;
          else if (m_load_left > 0) begin
            if (bus_if.op_valid) m_load_left--;
          end else if (m_comp_left > 0) begin
            if (bus_if.op_valid) m_comp_left--;
          end else begin
            m_drain_left--;
            if (m_drain_left == 0) begin
              m_fifo.push_back(m_busy);
              m_job = 0;
              m_jobs_done++;
            end
          end
        end
        // allocation sees the free set before any same-cycle release
        if (bus_if.cmd_valid && e_cmd_rdy) begin
          a = 0;
          for (int i = NA - 1; i >= 0; i--) if (m_free[(m_rr + i) % NA]) a = (m_rr + i) % NA;
          m_busy = a;
          m_free[a] = 1'b0;
          m_rr = (a + 1) % NA;
          m_job = 1;
          m_clr = bus_if.cmd_clear;
          m_load_left = AS;
          m_comp_left = (bus_if.cmd_len == 0) ? 1 : int'(bus_if.cmd_len);
          m_drain_left = DRAIN;
        end
        if (e_rv && bus_if.res_ready) begin
          if (m_row == AS - 1) begin
            m_free[m_fifo[0]] = 1'b1;
            void'(m_fifo.pop_front());
            m_row = 0;
          end else m_row++;
        end
        m_started = 1;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic clr_stats();
    cnt_clr = 0; cnt_load = 0; cnt_comp = 0; first_load = -1; last_load = -1;
  endtask

  task automatic send_cmd(input int len, input bit clr, input int budget);
    int n = 0;
    bit done = 0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_len   = LW'(len);
    bus_if.cmd_clear = clr;
    while (!done && n < budget) begin
      @(negedge clk);
      if (bus_if.cmd_ready) done = 1;
      n++;
    end
    if (!done) check_val("cmd_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_len   = LW'($urandom);
    bus_if.cmd_clear = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_model(input bit need_empty, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((m_job || (need_empty && m_fifo.size() != 0)) && n < budget);
    if (n >= budget) check_val("wait_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- scenarios
  initial begin
    int n;
    clr_stats();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #1 check_val("ready_rel0", bus_if.cmd_ready, 0);
    @(negedge clk); #1 check_val("ready_rel1", bus_if.cmd_ready, 1);
    @(posedge clk); #1;

    // single job with clear, operands always valid
    op_mode = 0; res_mode = 1; clr_stats();
    send_cmd(4, 1, 50);
    check_val("job1_array", busy_array, 0);
    wait_model(1, 300);
    check_val("job1_clr", cnt_clr, 1);
    check_val("job1_load", cnt_load, AS);
    check_val("job1_comp", cnt_comp, 4 + DRAIN);
    check_val("job1_free", free_mask, {NA{1'b1}});

    // zero length behaves as one compute beat
    clr_stats();
    send_cmd(0, 0, 50);
    wait_model(1, 300);
    check_val("len0_clr", cnt_clr, 0);
    check_val("len0_comp", cnt_comp, 1 + DRAIN);

    // toggling operand valid spreads loads over 2*AS-1 cycles
    op_mode = 1; clr_stats();
    send_cmd(2, 0, 50);
    wait_model(1, 300);
    check_val("tog_load", cnt_load, AS);
    check_val("tog_span", last_load - first_load + 1, 2 * AS - 1);

    // reset in the middle of compute
    op_mode = 0; clr_stats();
    send_cmd(5, 0, 50);
    n = 0;
    while (cnt_comp < 3 && n < 100) begin @(negedge clk); #1; n++; end
    check_val("mid_beat3", cnt_comp, 3);
    reset = 1'b0;
    #1;
    check_val("mid_rst_arr", {arr_clear_acc, arr_load_weights, arr_compute_enable}, 0);
    check_val("mid_rst_free", free_mask, 4'b1111);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #1 check_val("mid_rel0", bus_if.cmd_ready, 0);
    @(negedge clk); #1 check_val("mid_rel1", bus_if.cmd_ready, 1);
    @(posedge clk); #1;

    // fill the cluster with results held back
    res_mode = 0;
    for (int i = 0; i < NA; i++) begin
      send_cmd($urandom_range(1, 6), 1'($urandom_range(0, 1)), 100);
      check_val("fill_array", busy_array, i);
    end
    wait_model(0, 300);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_len   = 8'd3;
    bus_if.cmd_clear = 1'b1;
    repeat (10) begin @(negedge clk); #1 check_val("full_ready", bus_if.cmd_ready, 0); end
    check_val("full_free", free_mask, 0);
    @(posedge clk); #1;
    res_mode = 1;
    send_cmd(3, 1, 100);
    check_val("reuse_array", busy_array, 0);
    wait_model(1, 500);

    // randomized concurrent traffic
    op_mode = 2; res_mode = 2;
    for (int j = 0; j < 30; j++) begin
      send_cmd($urandom_range(0, 10), 1'($urandom_range(0, 1)), 2000);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    res_mode = 1;
    wait_model(1, 3000);
    check_val("end_free", free_mask, {NA{1'b1}});
`ifdef SEQ_PERF_CNT_EN
    check_val("perf_jobs", perf_jobs, m_jobs_done);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/systolic_cluster_sequencer.md
Name: systolic_cluster_sequencer

Overview:
- Next-generation control front-end for a cluster of NUM_ARRAYS systolic arrays of ARRAY_SIZE x ARRAY_SIZE, sitting between the job dispatcher and the arrays.
- Accepts matrix-multiply jobs over a valid/ready command interface and picks a free array round-robin.
- Sequences clear, weight load, compute and drain on that array over the shared operand bus.
- Queues completed arrays for row-by-row result readback; an array is reused only after its results have been read.

Parameters:
- NUM_ARRAYS, 8, arrays in cluster (2..16).
- ARRAY_SIZE, 8, array dimension; weight-load beats, drain base and readback rows.
- DATA_BITS, 16, Q1.15 operand width; forwarded to the operand bus.
- LEN_W, 8, width of compute beat count.
- IDX_W, $clog2(NUM_ARRAYS), array index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  job offered.
- cmd_ready  out  1  job accepted when valid&ready.
- cmd_len  in  LEN_W  compute beats K; 0 is treated as 1.
- cmd_clear  in  1  clear accumulators before the job.
- op_valid  in  1  operand beat present on a/b bus.
- op_ready  out  1  sequencer consumes operand beat.
- arr_clear_acc  out  NUM_ARRAYS  one-hot clear to arrays.
- arr_load_weights  out  NUM_ARRAYS  one-hot weight load.
- arr_compute_enable  out  NUM_ARRAYS  one-hot MAC enable.
- busy_array  out  IDX_W  array currently sequenced.
- res_valid  out  1  result row available.
- res_ready  in  1  consumer takes row.
- res_array  out  IDX_W  result mux select.
- res_row  out  $clog2(ARRAY_SIZE)  row index being presented.
- res_last  out  1  final row of this array.
- free_mask  out  NUM_ARRAYS  arrays available for allocation.

Behaviour:
- Reset (reset=0, async) clears all registers. Outputs at reset: cmd_ready=0, op_ready=0, all arr_* = 0, busy_array=0, res_valid=0, res_array=0, res_row=0, res_last=0, free_mask=all ones. First cycle after reset release: cmd_ready=1.
- FSM states: IDLE, CLEAR, LOAD, COMPUTE, DRAIN.
  - IDLE: cmd_ready = (free_mask != 0). On handshake:
    - latch K = max(cmd_len,1).
    - choose first free array at or after rr_ptr (wrapping); set busy_array; clear its free bit.
    - rr_ptr <= chosen+1 mod NUM_ARRAYS.
    - next state CLEAR if cmd_clear, else LOAD.
  - CLEAR: one cycle; arr_clear_acc[busy]=1; -> LOAD.
  - LOAD: op_ready=1; each op_valid beat asserts arr_load_weights[busy] in the same cycle. After ARRAY_SIZE beats -> COMPUTE. No beat, no pulse; stalls are unbounded.
  - COMPUTE: op_ready=1; each beat asserts arr_compute_enable[busy]. After K beats -> DRAIN.
  - DRAIN: arr_compute_enable[busy]=1 for 2*ARRAY_SIZE-2 cycles with op_ready=0 (pipeline flush). Then push busy into done FIFO (depth NUM_ARRAYS) and -> IDLE.
- Control outputs are combinational from state/beat and mutually exclusive; at most one bit across all arr_* vectors is high per cycle.
- Readback runs independently of the FSM, concurrently with another job:
  - res_valid = done FIFO non-empty; res_array = FIFO head.
  - Rows 0..ARRAY_SIZE-1 are presented in order; res_row advances on valid&ready.
  - res_last = (res_row==ARRAY_SIZE-1). On the last handshake: pop FIFO, set free_mask bit, res_row <= 0.
- Simultaneous release and allocation in one cycle: the IDLE allocation sees the pre-release free_mask. The released array becomes available the next cycle.
- Done FIFO cannot overflow: entries never exceed NUM_ARRAYS.
- cmd_ready stays 0 outside IDLE. cmd fields are sampled only at handshake.
- Reset mid-job aborts the job; no partial pulse on arr_* after reset asserts.

Optional Feature:
- SEQ_PERF_CNT_EN defined: adds three 32-bit outputs, cleared at reset, saturating at all-ones:
  - perf_jobs: jobs completed (counts at DRAIN exit).
  - perf_op_stall: cycles in LOAD/COMPUTE with op_valid=0.
  - perf_full_stall: cycles cmd_valid=1 and free_mask=0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset mid-COMPUTE (NUM_ARRAYS=4, K=5, reset low at beat 3) -> all arr_* 0 in the same cycle, free_mask=4'b1111, cmd_ready=1 one cycle after release.
- Single job, K=4, cmd_clear=1, op_valid held high -> sequence on array 0:
  - 1 clear pulse, then 8 load pulses, then 4 compute beats, then 14 drain cycles.
  - res_valid rises and res_array=0; rows 0..7 with res_last on row 7; free_mask returns to all ones.
- cmd_len=0 -> exactly 1 compute beat.
- op_valid toggling 1,0,1,0 in LOAD -> 8 load pulses spread over 15 cycles; no pulse in gap cycles.
- NUM_ARRAYS=4, 5 back-to-back jobs, res_ready=0:
  - arrays allocated 0,1,2,3; cmd_ready=0 afterwards.
  - raising res_ready frees array 0; the 5th job then goes to array 0.
- Readback of array 1 while array 2 is in COMPUTE -> both progress; exactly one arr_* bit high per cycle; result rows are unaffected.
